// File: rtl/logic_stream_unit.sv
// Registered AND/OR/XOR stream unit on valid/ready handshakes, with optional
// packet folding that emits one result and a beat count per packet.
//   state   | meaning
//   ST_IDLE | no packet in progress; next accepted beat starts a packet and locks the op
//   ST_BUSY | packet open; accumulator and beat counter hold the partial fold
module logic_stream_unit #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int ACCUM = 0,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_a,
  input  logic [WIDTH-1:0] i_in_b,
  input  logic             i_in_last,
  input  logic [1:0]       i_op_sel,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data,
  output logic [CNT_W-1:0] o_out_count
);

  typedef enum logic [1:0] {OP_AND = 2'd0, OP_OR = 2'd1, OP_XOR = 2'd2, OP_ZERO = 2'd3} op_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);
  localparam logic [1:0]       LP_MODE_OP = MODE[1:0];

  function automatic logic [WIDTH-1:0] apply_op(input op_t op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  op_t              r_lock_op, w_op;
  logic [WIDTH-1:0] r_acc, w_acc_nxt, w_beat, w_fold, w_load_data, r_out_data;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc, w_load_cnt, r_out_count;
  logic             r_out_valid, w_accept, w_load;

  assign o_in_ready  = ~r_out_valid | i_out_ready;
  assign w_accept    = i_in_valid & o_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_out_count = r_out_count;

  // In folding builds the op latched on the first beat governs the whole packet.
  always_comb begin
    w_op = OP_ZERO;
    if (MODE >= 0 && MODE <= 2) begin
      w_op = op_t'(LP_MODE_OP);
    end else if (MODE == 3) begin
      if (ACCUM != 0 && r_state == ST_BUSY) w_op = r_lock_op;
      else                                  w_op = op_t'(i_op_sel);
    end
  end

  assign w_beat    = apply_op(w_op, i_in_a, i_in_b);
  assign w_fold    = apply_op(w_op, r_acc, w_beat);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + LP_CNT_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_load_data = w_beat;
    w_load_cnt  = LP_CNT_ONE;
    if (ACCUM == 0) begin
      w_load = w_accept;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            if (i_in_last) begin
              w_load = 1'b1;
            end else begin
              w_acc_nxt   = w_beat;
              w_cnt_nxt   = LP_CNT_ONE;
              w_state_nxt = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (w_accept) begin
            if (i_in_last) begin
              w_load      = 1'b1;
              w_load_data = w_fold;
              w_load_cnt  = w_cnt_inc;
              w_acc_nxt   = '0;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_IDLE;
            end else begin
              w_acc_nxt = w_fold;
              w_cnt_nxt = w_cnt_inc;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_lock_op   <= OP_AND;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept && r_state == ST_IDLE) r_lock_op <= w_op;
      // A load in the same cycle as a pop replaces the result without a bubble.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
        r_out_count <= w_load_cnt;
      end else if (r_out_valid && i_out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_logic_stream_unit.sv
// Bench for logic_stream_unit: six builds (fixed, runtime, folding, zero-mode)
// driven side by side, checked against a packet-level reference model.
module tb_logic_stream_unit;

  localparam int NDUT = 6;

  function automatic int cfg_mode(input int k);
    case (k)
      0: return 0;
      1: return 3;
      2: return 2;
      3: return 3;
      4: return 0;
      default: return 5;
    endcase
  endfunction

  function automatic int cfg_accum(input int k);
    return (k <= 1) ? 0 : 1;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid [NDUT];
  logic       in_ready [NDUT];
  logic [7:0] in_a     [NDUT];
  logic [7:0] in_b     [NDUT];
  logic       in_last  [NDUT];
  logic [1:0] op_sel   [NDUT];
  logic       out_valid[NDUT];
  logic       out_ready[NDUT];
  logic [7:0] out_data [NDUT];
  logic [7:0] out_count[NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic_stream_unit #(.WIDTH(8), .MODE(cfg_mode(g)), .ACCUM(cfg_accum(g)), .CNT_W(8)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_in_valid(in_valid[g]), .o_in_ready(in_ready[g]),
      .i_in_a(in_a[g]), .i_in_b(in_b[g]), .i_in_last(in_last[g]), .i_op_sel(op_sel[g]),
      .o_out_valid(out_valid[g]), .i_out_ready(out_ready[g]),
      .o_out_data(out_data[g]), .o_out_count(out_count[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: result register plus the list of per-beat results of the open packet.
  logic       m_valid[NDUT];
  logic [7:0] m_data [NDUT];
  logic [7:0] m_count[NDUT];
  int         m_lop  [NDUT];
  logic [7:0] m_beats[NDUT][$];

  function automatic logic [7:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return a ^ b;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_update(input int k);
    int mode, op;
    logic acc, pop;
    logic [7:0] r, res;
    mode = cfg_mode(k);
    if (!rst_n) begin
      m_valid[k] = 1'b0; m_data[k] = 8'h00; m_count[k] = 8'h00; m_lop[k] = 0;
      m_beats[k].delete();
      return;
    end
    acc = in_valid[k] && (!m_valid[k] || out_ready[k]);
    pop = m_valid[k] && out_ready[k];
    if (pop) m_valid[k] = 1'b0;
    if (acc) begin
      if (mode < 3) op = mode;
      else if (mode == 3) begin
        if (cfg_accum(k) == 0 || m_beats[k].size() == 0) op = int'(op_sel[k]);
        else op = m_lop[k];
        if (m_beats[k].size() == 0) m_lop[k] = int'(op_sel[k]);
      end else op = 3;
      r = ref_op(op, in_a[k], in_b[k]);
      if (cfg_accum(k) == 0) begin
        m_valid[k] = 1'b1; m_data[k] = r; m_count[k] = 8'd1;
      end else begin
        m_beats[k].push_back(r);
        if (in_last[k]) begin
          res = m_beats[k][0];
          for (int i = 1; i < m_beats[k].size(); i++) res = ref_op(op, res, m_beats[k][i]);
          m_valid[k] = 1'b1;
          m_data[k]  = res;
          m_count[k] = (m_beats[k].size() > 255) ? 8'd255 : 8'(m_beats[k].size());
          m_beats[k].delete();
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < NDUT; k++) model_update(k);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k] = 1'b0; in_last[k] = 1'b0; in_a[k] = 8'h00; in_b[k] = 8'h00;
      op_sel[k] = 2'd0; out_ready[k] = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_all();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      n_cmp++; if (out_valid[k] !== 1'b0) begin n_bad++; $display("FAIL reset_valid dut%0d got=%b want=0", k, out_valid[k]); end
      n_cmp++; if (out_data[k] !== 8'h00) begin n_bad++; $display("FAIL reset_data dut%0d got=%h want=00", k, out_data[k]); end
      n_cmp++; if (out_count[k] !== 8'h00) begin n_bad++; $display("FAIL reset_count dut%0d got=%0d want=0", k, out_count[k]); end
      n_cmp++; if (in_ready[k] !== 1'b1) begin n_bad++; $display("FAIL reset_ready dut%0d got=%b want=1", k, in_ready[k]); end
    end
  endtask

  task automatic test_fixed_and();
    in_valid[0] = 1'b1; in_a[0] = 8'hF0; in_b[0] = 8'h3C;
    tick();
    in_valid[0] = 1'b0;
    n_cmp++; if (out_valid[0] !== 1'b1) begin n_bad++; $display("FAIL and_valid got=%b want=1", out_valid[0]); end
    n_cmp++; if (out_data[0] !== 8'h30) begin n_bad++; $display("FAIL and_data got=%h want=30", out_data[0]); end
    n_cmp++; if (out_count[0] !== 8'd1) begin n_bad++; $display("FAIL and_count got=%0d want=1", out_count[0]); end
    tick();
  endtask

  task automatic test_runtime_ops();
    logic [7:0] want[4];
    want = '{8'h0A, 8'hAF, 8'hA5, 8'h00};
    for (int i = 0; i < 4; i++) begin
      in_valid[1] = 1'b1; in_a[1] = 8'hAA; in_b[1] = 8'h0F; op_sel[1] = 2'(i);
      #1;
      n_cmp++; if (in_ready[1] !== 1'b1) begin n_bad++; $display("FAIL rt_ready beat%0d got=%b want=1", i, in_ready[1]); end
      tick();
      n_cmp++; if (out_valid[1] !== 1'b1 || out_data[1] !== want[i]) begin
        n_bad++; $display("FAIL rt_data beat%0d got=%b/%h want=1/%h", i, out_valid[1], out_data[1], want[i]);
      end
    end
    in_valid[1] = 1'b0;
    tick();
    n_cmp++; if (out_valid[1] !== 1'b0) begin n_bad++; $display("FAIL rt_drain got=%b want=0", out_valid[1]); end
  endtask

  task automatic test_xor_fold();
    logic [7:0] av[4];
    av = '{8'h01, 8'h02, 8'h04, 8'h80};
    for (int i = 0; i < 4; i++) begin
      in_valid[2] = 1'b1; in_a[2] = av[i]; in_b[2] = 8'h00; in_last[2] = (i == 3);
      tick();
      if (i < 3) begin
        n_cmp++; if (out_valid[2] !== 1'b0) begin n_bad++; $display("FAIL fold_early beat%0d got=%b want=0", i, out_valid[2]); end
      end
    end
    in_valid[2] = 1'b0; in_last[2] = 1'b0;
    n_cmp++; if (out_valid[2] !== 1'b1 || out_data[2] !== 8'h87) begin
      n_bad++; $display("FAIL fold_data got=%b/%h want=1/87", out_valid[2], out_data[2]);
    end
    n_cmp++; if (out_count[2] !== 8'd4) begin n_bad++; $display("FAIL fold_count got=%0d want=4", out_count[2]); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [7:0] aa[$], bb[$], got[$];
    logic [7:0] held;
    int idx, cyc;
    idx = 0; cyc = 0; held = 8'h00;
    for (int i = 0; i < 6; i++) begin aa.push_back(8'($urandom)); bb.push_back(8'($urandom)); end
    while (got.size() < 6 && cyc < 40) begin
      in_valid[0] = (idx < 6);
      if (idx < 6) begin in_a[0] = aa[idx]; in_b[0] = bb[idx]; end
      out_ready[0] = !(cyc >= 1 && cyc <= 3);
      #1;
      n_cmp++; if (in_ready[0] !== (!m_valid[0] || out_ready[0])) begin
        n_bad++; $display("FAIL bp_ready cyc%0d got=%b want=%b", cyc, in_ready[0], !m_valid[0] || out_ready[0]);
      end
      if (cyc == 1) held = out_data[0];
      if (cyc >= 2 && cyc <= 3) begin
        n_cmp++; if (out_valid[0] !== 1'b1 || out_data[0] !== held) begin
          n_bad++; $display("FAIL bp_hold cyc%0d got=%b/%h want=1/%h", cyc, out_valid[0], out_data[0], held);
        end
      end
      if (out_valid[0] && out_ready[0]) got.push_back(out_data[0]);
      if (in_valid[0] && in_ready[0]) idx++;
      tick();
      cyc++;
    end
    in_valid[0] = 1'b0; out_ready[0] = 1'b1;
    n_cmp++; if (got.size() != 6) begin n_bad++; $display("FAIL bp_count got=%0d want=6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_cmp++; if (got[i] !== (aa[i] & bb[i])) begin
        n_bad++; $display("FAIL bp_order idx%0d got=%h want=%h", i, got[i], aa[i] & bb[i]);
      end
    end
    tick();
  endtask

  task automatic test_lock();
    logic [7:0] av[3];
    logic [1:0] ov[3];
    av = '{8'h01, 8'h10, 8'h04};
    ov = '{2'd1, 2'd0, 2'd0};
    for (int i = 0; i < 3; i++) begin
      in_valid[3] = 1'b1; in_a[3] = av[i]; in_b[3] = 8'h00; op_sel[3] = ov[i]; in_last[3] = (i == 2);
      tick();
    end
    in_valid[3] = 1'b0; in_last[3] = 1'b0;
    n_cmp++; if (out_valid[3] !== 1'b1 || out_data[3] !== 8'h15) begin
      n_bad++; $display("FAIL lock_data got=%b/%h want=1/15", out_valid[3], out_data[3]);
    end
    n_cmp++; if (out_count[3] !== 8'd3) begin n_bad++; $display("FAIL lock_count got=%0d want=3", out_count[3]); end
    tick();
  endtask

  task automatic test_reset_abort();
    for (int i = 0; i < 2; i++) begin
      in_valid[4] = 1'b1; in_a[4] = 8'($urandom); in_b[4] = 8'($urandom); in_last[4] = 1'b0;
      tick();
    end
    in_valid[4] = 1'b1; in_last[4] = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; in_valid[4] = 1'b0; in_last[4] = 1'b0;
    n_cmp++; if (out_valid[4] !== 1'b0) begin n_bad++; $display("FAIL abort_reset got=%b want=0", out_valid[4]); end
    in_valid[4] = 1'b1; in_a[4] = 8'h0F; in_b[4] = 8'hFF; in_last[4] = 1'b1;
    tick();
    in_valid[4] = 1'b0; in_last[4] = 1'b0;
    n_cmp++; if (out_valid[4] !== 1'b1 || out_data[4] !== 8'h0F || out_count[4] !== 8'd1) begin
      n_bad++; $display("FAIL abort_single got=%b/%h/%0d want=1/0f/1", out_valid[4], out_data[4], out_count[4]);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid[4] !== 1'b0) begin n_bad++; $display("FAIL abort_ghost cyc%0d got=%b want=0", i, out_valid[4]); end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] orv;
    orv = 8'h00;
    for (int i = 0; i < 260; i++) begin
      in_valid[3] = 1'b1; in_a[3] = 8'($urandom); in_b[3] = 8'h00; in_last[3] = (i == 259);
      op_sel[3] = (i == 0) ? 2'd1 : 2'($urandom);
      orv = orv | in_a[3];
      tick();
    end
    in_valid[3] = 1'b0; in_last[3] = 1'b0;
    n_cmp++; if (out_valid[3] !== 1'b1 || out_data[3] !== orv) begin
      n_bad++; $display("FAIL sat_data got=%b/%h want=1/%h", out_valid[3], out_data[3], orv);
    end
    n_cmp++; if (out_count[3] !== 8'd255) begin n_bad++; $display("FAIL sat_count got=%0d want=255", out_count[3]); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NDUT; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_a[k]      = 8'($urandom);
        in_b[k]      = 8'($urandom);
        in_last[k]   = ($urandom_range(0, 3) == 0);
        op_sel[k]    = 2'($urandom);
        out_ready[k] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int k = 0; k < NDUT; k++) begin
        n_cmp++; if (in_ready[k] !== (!m_valid[k] || out_ready[k])) begin
          n_bad++; $display("FAIL rnd_ready dut%0d cyc%0d got=%b want=%b", k, c, in_ready[k], !m_valid[k] || out_ready[k]);
        end
      end
      tick();
      for (int k = 0; k < NDUT; k++) begin
        n_cmp++; if (out_valid[k] !== m_valid[k]) begin
          n_bad++; $display("FAIL rnd_valid dut%0d cyc%0d got=%b want=%b", k, c, out_valid[k], m_valid[k]);
        end else if (m_valid[k] && (out_data[k] !== m_data[k] || out_count[k] !== m_count[k])) begin
          n_bad++; $display("FAIL rnd_data dut%0d cyc%0d got=%h/%0d want=%h/%0d", k, c,
                            out_data[k], out_count[k], m_data[k], m_count[k]);
        end
      end
    end
    idle_all();
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fixed_and();
    test_runtime_ops();
    test_xor_fold();
    test_backpressure();
    test_lock();
    test_reset_abort();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
